b2bcd_seq: RTL and testbench

//  Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.

---
 rtl/b2bcd_seq_if.sv | 36 +++
 rtl/b2bcd_seq.sv | 150 +++++++++++++++
 tb/tb_b2bcd_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/b2bcd_seq_if.sv
// Handshake and result bus for the sequential binary-to-BCD converter.
// in_valid/in_ready: a value on din is taken on any rising clk edge where
// both are high. dout_valid is a one-cycle pulse with no back-pressure;
// dout/ovf (and blank when B2BCD_BLANK_EN is defined) hold until the next result.
interface b2bcd_seq_if #(
   parameter int BIN_W  = 24,
   parameter int DIGITS = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      din;
   logic                  dout_valid;
   logic [4*DIGITS-1:0]   dout;
   logic                  ovf;
`ifdef B2BCD_BLANK_EN
   logic [DIGITS-1:0]     blank;
`endif

   // Converter side
   modport slave (
`ifdef B2BCD_BLANK_EN
      output blank,
`endif
      input  in_valid, din,
      output in_ready, dout_valid, dout, ovf
   );

   // Producer / consumer side
   modport master (
`ifdef B2BCD_BLANK_EN
      input  blank,
`endif
      output in_valid, din,
      input  in_ready, dout_valid, dout, ovf
   );
endinterface

// File: rtl/b2bcd_seq.sv
// b2bcd_seq: sequential binary-to-packed-BCD converter (double dabble),
// one input bit per clock. A conversion takes BIN_W clocks from accept to
// the dout_valid pulse. Digits beyond DIGITS are dropped and flagged on ovf.
// Optional macro B2BCD_BLANK_EN adds a registered leading-zero mask (blank).
module b2bcd_seq #(
   parameter int BIN_W  = 24,
   parameter int DIGITS = 8
) (
   input  logic          clk,
   input  logic          rst,
   b2bcd_seq_if.slave    bus,
   output logic          state_dbg_o   // 1 while a conversion is shifting
);

   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int BCD_W = 4 * DIGITS;

   generate
      if (DIGITS < 1 || BIN_W < 1) begin : g_param_err
         $error("b2bcd_seq: BIN_W and DIGITS must both be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
   logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic [BCD_W-1:0]   dout_q, dout_d;
   logic               ovf_q, ovf_d;
   logic               dout_valid_q, dout_valid_d;

   logic [BCD_W-1:0]   corr;       // bcd_sr after per-nibble add-3
   logic [BCD_W-1:0]   shifted;    // corr shifted left with next binary bit
   logic               out_bit;    // bit leaving the top digit (overflow)
   logic               last_shift;

`ifdef B2BCD_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
   logic [DIGITS-1:0]  blank_q, blank_d, blank_nx;
`endif

   // Double-dabble step: add 3 to each digit >= 5 (no carry between nibbles), then shift
   always_comb begin
      corr = bcd_sr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_sr_q[4*i +: 4] >= 4'd5)
            corr[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
      end
      shifted    = {corr[BCD_W-2:0], bin_sr_q[BIN_W-1]};
      out_bit    = corr[BCD_W-1];
      last_shift = (cnt_q == CNT_W'(BIN_W - 1));
   end

`ifdef B2BCD_BLANK_EN
   // Leading-zero mask of the result about to be latched; units digit always shown
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank_nx = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run & (shifted[4*i +: 4] == 4'd0);
         blank_nx[i] = zero_run;
      end
   end
`endif

   // Next-state and datapath control
   always_comb begin
      state_d      = state_q;
      bin_sr_d     = bin_sr_q;
      bcd_sr_d     = bcd_sr_q;
      cnt_d        = cnt_q;
      ovf_acc_d    = ovf_acc_q;
      dout_d       = dout_q;
      ovf_d        = ovf_q;
      dout_valid_d = 1'b0;
`ifdef B2BCD_BLANK_EN
      blank_d      = blank_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bin_sr_d  = bus.din;
               bcd_sr_d  = '0;
               cnt_d     = '0;
               ovf_acc_d = 1'b0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            bcd_sr_d  = shifted;
            bin_sr_d  = bin_sr_q << 1;
            ovf_acc_d = ovf_acc_q | out_bit;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_shift) begin
               dout_d       = shifted;
               ovf_d        = ovf_acc_q | out_bit;
               dout_valid_d = 1'b1;
               state_d      = IDLE;
`ifdef B2BCD_BLANK_EN
               blank_d      = blank_nx;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bin_sr_q     <= '0;
         bcd_sr_q     <= '0;
         cnt_q        <= '0;
         ovf_acc_q    <= 1'b0;
         dout_q       <= '0;
         ovf_q        <= 1'b0;
         dout_valid_q <= 1'b0;
`ifdef B2BCD_BLANK_EN
         blank_q      <= BLANK_RST;
`endif
      end else begin
         state_q      <= state_d;
         bin_sr_q     <= bin_sr_d;
         bcd_sr_q     <= bcd_sr_d;
         cnt_q        <= cnt_d;
         ovf_acc_q    <= ovf_acc_d;
         dout_q       <= dout_d;
         ovf_q        <= ovf_d;
         dout_valid_q <= dout_valid_d;
`ifdef B2BCD_BLANK_EN
         blank_q      <= blank_d;
`endif
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout       = dout_q;
   assign bus.ovf        = ovf_q;
`ifdef B2BCD_BLANK_EN
   assign bus.blank      = blank_q;
`endif
   assign state_dbg_o    = (state_q == SHIFT);

endmodule

// File: tb/tb_b2bcd_seq.sv
// Bench for b2bcd_seq: an 8-digit and a 6-digit instance, both 24-bit input,
// compared against a decimal-arithmetic reference model.
module tb_b2bcd_seq;

   logic clk;
   logic rst;
   logic dbg8, dbg6;
   int   errors = 0;
   int   checks = 0;
   logic [32:0] exp_q[$];   // {ovf, dout} expected, in issue order

   b2bcd_seq_if #(.BIN_W(24), .DIGITS(8)) bus8 ();
   b2bcd_seq_if #(.BIN_W(24), .DIGITS(6)) bus6 ();

   b2bcd_seq #(.BIN_W(24), .DIGITS(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .state_dbg_o(dbg8));
   b2bcd_seq #(.BIN_W(24), .DIGITS(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6), .state_dbg_o(dbg6));

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: decimal digits by division, {ovf, packed BCD mod 10^nd}
   function automatic logic [32:0] ref_conv(input longint v, input int nd);
      longint r, lim;
      logic [31:0] d;
      r = v; lim = 1; d = '0;
      for (int i = 0; i < nd; i++) begin
         d[4*i +: 4] = 4'(r % 10);
         r = r / 10;
         lim = lim * 10;
      end
      return {(v >= lim), d};
   endfunction

   // reference: blank[i]=1 for every digit position at or above the decimal length (min length 1)
   function automatic logic [7:0] ref_blank(input longint v);
      int n;
      longint r;
      logic [7:0] b;
      n = 1; r = v / 10;
      while (r != 0) begin n++; r = r / 10; end
      b = '0;
      for (int i = 1; i < 8; i++) b[i] = (i >= n);
      return b;
   endfunction

   // driver: one conversion on the 8-digit instance, returns result and latency (-1 on timeout)
   task automatic run8(input logic [23:0] v, output logic [31:0] d, output logic o, output int lat);
      int n;
      n = 0;
      while (!bus8.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.din = v;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0; bus8.din = 24'($urandom);
      lat = -1; d = '0; o = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (bus8.dout_valid) begin lat = c; d = bus8.dout; o = bus8.ovf; break; end
      end
   endtask

   // driver: one conversion on the 6-digit instance
   task automatic run6(input logic [23:0] v, output logic [31:0] d, output logic o, output int lat);
      int n;
      n = 0;
      while (!bus6.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(negedge clk);
      bus6.in_valid = 1'b1; bus6.din = v;
      @(posedge clk); #1;
      bus6.in_valid = 1'b0; bus6.din = 24'($urandom);
      lat = -1; d = '0; o = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (bus6.dout_valid) begin lat = c; d = 32'(bus6.dout); o = bus6.ovf; break; end
      end
   endtask

   task automatic test_reset;
      checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
      checks++; if (bus8.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%b exp=0", bus8.dout_valid); end
      checks++; if (bus8.dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus8.dout); end
      checks++; if (bus8.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus8.ovf); end
      checks++; if (dbg8 !== 1'b0) begin errors++; $display("FAIL reset_state got=%b exp=0", dbg8); end
      checks++; if (bus6.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready6 got=%b exp=1", bus6.in_ready); end
`ifdef B2BCD_BLANK_EN
      checks++; if (bus8.blank !== 8'b1111_1110) begin errors++; $display("FAIL reset_blank got=%b exp=11111110", bus8.blank); end
`endif
   endtask

   task automatic test_known;
      logic [23:0] vals[3];
      logic [31:0] expd[3];
      logic [31:0] d; logic o; int lat;
      vals = '{24'd999999, 24'hFFFFFF, 24'd0};
      expd = '{32'h00999999, 32'h16777215, 32'h00000000};
      for (int k = 0; k < 3; k++) begin
         run8(vals[k], d, o, lat);
         checks++; if (lat !== 24) begin errors++; $display("FAIL known_latency din=%0d got=%0d exp=24", vals[k], lat); end
         checks++; if (d !== expd[k]) begin errors++; $display("FAIL known_dout din=%0d got=%h exp=%h", vals[k], d, expd[k]); end
         checks++; if (o !== 1'b0) begin errors++; $display("FAIL known_ovf din=%0d got=%b exp=0", vals[k], o); end
         checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL known_ready_with_valid got=%b exp=1", bus8.in_ready); end
      end
   endtask

   task automatic test_overflow;
      logic [23:0] vals[2];
      logic [31:0] expd[2];
      logic [31:0] d; logic o; int lat;
      vals = '{24'd1000000, 24'd1234567};
      expd = '{32'h000000, 32'h234567};
      for (int k = 0; k < 2; k++) begin
         run6(vals[k], d, o, lat);
         checks++; if (lat !== 24) begin errors++; $display("FAIL ovf_latency din=%0d got=%0d exp=24", vals[k], lat); end
         checks++; if (d !== expd[k]) begin errors++; $display("FAIL ovf_dout din=%0d got=%h exp=%h", vals[k], d, expd[k]); end
         checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag din=%0d got=%b exp=1", vals[k], o); end
      end
   endtask

   task automatic test_back_to_back;
      logic [23:0] vals[2];
      logic [31:0] got[2];
      int t[2];
      int idx, pulses;
      logic [31:0] held;
      vals = '{24'd5, 24'd10};
      idx = 0; pulses = 0; held = '0;
      t = '{-1, -1}; got = '{32'h0, 32'h0};
      @(negedge clk);
      for (int c = 0; c < 80; c++) begin
         if (bus8.in_ready && idx < 2) begin
            bus8.in_valid = 1'b1; bus8.din = vals[idx]; idx++;
         end else if (bus8.in_ready) begin
            bus8.in_valid = 1'b0;
         end else begin
            bus8.din = 24'($urandom);   // must be ignored while busy
         end
         @(posedge clk); #1;
         if (bus8.dout_valid) begin
            if (pulses < 2) begin t[pulses] = c; got[pulses] = bus8.dout; end
            pulses++;
         end
         if (c == 40) held = bus8.dout;
         @(negedge clk);
      end
      bus8.in_valid = 1'b0;
      checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
      checks++; if (t[0] !== 24) begin errors++; $display("FAIL b2b_time0 got=%0d exp=24", t[0]); end
      checks++; if (t[1] !== 49) begin errors++; $display("FAIL b2b_time1 got=%0d exp=49", t[1]); end
      checks++; if (got[0] !== 32'h05) begin errors++; $display("FAIL b2b_dout0 got=%h exp=05", got[0]); end
      checks++; if (got[1] !== 32'h10) begin errors++; $display("FAIL b2b_dout1 got=%h exp=10", got[1]); end
      checks++; if (held !== 32'h05) begin errors++; $display("FAIL b2b_dout_held got=%h exp=05", held); end
   endtask

   task automatic test_random;
      logic [23:0] v;
      logic [32:0] e;
      logic [31:0] d; logic o; int lat;
      for (int k = 0; k < 24; k++) begin
         case (k % 3)
            0: v = 24'($urandom_range(0, 99));
            1: v = 24'($urandom_range(0, 999999));
            default: v = 24'($urandom_range(0, 24'hFFFFFF));
         endcase
         exp_q.push_back(ref_conv(longint'(v), 8));
         run8(v, d, o, lat);
         e = exp_q.pop_front();
         checks++; if ({o, d} !== e) begin errors++; $display("FAIL rand8 din=%0d got=%b/%h exp=%b/%h", v, o, d, e[32], e[31:0]); end
         checks++; if (lat !== 24) begin errors++; $display("FAIL rand8_latency din=%0d got=%0d exp=24", v, lat); end
`ifdef B2BCD_BLANK_EN
         checks++; if (bus8.blank !== ref_blank(longint'(v))) begin errors++; $display("FAIL rand8_blank din=%0d got=%b exp=%b", v, bus8.blank, ref_blank(longint'(v))); end
`endif
      end
      for (int k = 0; k < 12; k++) begin
         v = (k % 2 == 0) ? 24'($urandom_range(0, 999999)) : 24'($urandom_range(1000000, 24'hFFFFFF));
         exp_q.push_back(ref_conv(longint'(v), 6));
         run6(v, d, o, lat);
         e = exp_q.pop_front();
         checks++; if ({o, d} !== e) begin errors++; $display("FAIL rand6 din=%0d got=%b/%h exp=%b/%h", v, o, d, e[32], e[31:0]); end
      end
   endtask

   task automatic test_blank;
`ifdef B2BCD_BLANK_EN
      logic [23:0] vals[3];
      logic [7:0]  expb[3];
      logic [31:0] d; logic o; int lat;
      vals = '{24'd42, 24'd0, 24'hFFFFFF};
      expb = '{8'b1111_1100, 8'b1111_1110, 8'h00};
      for (int k = 0; k < 3; k++) begin
         run8(vals[k], d, o, lat);
         checks++; if (bus8.blank !== expb[k]) begin errors++; $display("FAIL blank din=%0d got=%b exp=%b", vals[k], bus8.blank, expb[k]); end
      end
`endif
   endtask

   task automatic test_reset_mid;
      int seen;
      logic [31:0] d; logic o; int lat;
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.din = 24'd123456;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", bus8.in_ready); end
      checks++; if (bus8.dout !== 32'h0) begin errors++; $display("FAIL midrst_dout got=%h exp=0", bus8.dout); end
      checks++; if (bus8.ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", bus8.ovf); end
      checks++; if (dbg8 !== 1'b0) begin errors++; $display("FAIL midrst_state got=%b exp=0", dbg8); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_next got=%b exp=1", bus8.in_ready); end
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus8.dout_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid got=%0d pulses exp=0", seen); end
      run8(24'd654321, d, o, lat);
      checks++; if ({o, d} !== {1'b0, 32'h00654321} || lat !== 24) begin
         errors++; $display("FAIL midrst_recover got=%b/%h lat=%0d exp=0/00654321 lat=24", o, d, lat);
      end
   endtask

   // reset and test sequence
   initial begin
      rst = 1'b1;
      bus8.in_valid = 1'b0; bus8.din = '0;
      bus6.in_valid = 1'b0; bus6.din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      test_reset();
      test_known();
      test_overflow();
      test_back_to_back();
      test_random();
      test_blank();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
